// File: rtl/instr_fetch_pkg.sv
// Shared constants and helpers for the MIPS instruction fetch stage.
package instr_fetch_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] next_word(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface instr_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_rvalid);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_rvalid);

endinterface

// File: rtl/instr_fetch_branch_target.sv
// Redirect target for the instruction in ID: JR/JALR, then J/JAL, then taken branch.
module instr_fetch_branch_target
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc_id_i,
  input  logic [25:0] instr_index_i,
  input  logic [31:0] jr_pc_i,
  input  logic        jump_reg_i,
  input  logic        jump_target_i,
  input  logic        jump_branch_i,
  output logic [31:0] target_o
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;

  assign pc_plus4      = next_word(pc_id_i);
  assign branch_offset = {{14{instr_index_i[15]}}, instr_index_i[15:0], 2'b00};

  always_comb begin
    target_o = pc_plus4;
    if (jump_reg_i) begin
      target_o = jr_pc_i;
    end else if (jump_target_i) begin
      target_o = {pc_plus4[31:28], instr_index_i, 2'b00};
    end else if (jump_branch_i) begin
      target_o = pc_plus4 + branch_offset;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: keeps the fetch PC, issues one imem request at a time
// and feeds decode, honouring stall and single-delay-slot redirects.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          jump_branch,
  input  logic          jump_target,
  input  logic          jump_reg,
  input  logic [31:0]   jr_pc,
  instr_fetch_if.master imem,
  output logic [31:0]   instr_id,
  output logic [31:0]   pc_id,
  output logic          valid_id
);

  typedef enum logic [1:0] {S_START, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_fetch_q, pc_fetch_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_id_q, valid_id_d;
  logic        redirect_pending_q, redirect_pending_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] target;
  logic        redirect;
  logic        issue;
  logic [31:0] issue_addr;

  instr_fetch_branch_target u_branch_target (
    .pc_id_i       (pc_id_q),
    .instr_index_i (instr_id_q[25:0]),
    .jr_pc_i       (jr_pc),
    .jump_reg_i    (jump_reg),
    .jump_target_i (jump_target),
    .jump_branch_i (jump_branch),
    .target_o      (target)
  );

  assign redirect = valid_id_q & ~stall & (jump_reg | jump_target | jump_branch);

  always_comb begin
    state_d            = state_q;
    pc_fetch_d         = pc_fetch_q;
    hold_d             = hold_q;
    instr_id_d         = instr_id_q;
    pc_id_d            = pc_id_q;
    valid_id_d         = valid_id_q;
    redirect_pending_d = redirect_pending_q;
    redirect_pc_d      = redirect_pc_q;
    issue              = 1'b0;
    issue_addr         = redirect ? target
                       : (redirect_pending_q ? redirect_pc_q : next_word(pc_fetch_q));

    // pc_fetch_q still names the outstanding or held word until the next issue
    unique case (state_q)
      S_START: begin
        issue      = 1'b1;
        issue_addr = RESET_PC;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (stall) begin
            hold_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end else begin
            instr_id_d = imem.imem_rdata;
            pc_id_d    = pc_fetch_q;
            valid_id_d = 1'b1;
            issue      = 1'b1;
          end
        end else if (!stall) begin
          instr_id_d = NOP;
          valid_id_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          instr_id_d = hold_q;
          pc_id_d    = pc_fetch_q;
          valid_id_d = 1'b1;
          issue      = 1'b1;
          state_d    = S_WAIT;
        end
      end
      default: state_d = S_START;
    endcase

    // A redirect that cannot issue now waits for the delay slot to return
    if (issue) begin
      pc_fetch_d         = issue_addr;
      redirect_pending_d = 1'b0;
    end else if (redirect) begin
      redirect_pending_d = 1'b1;
      redirect_pc_d      = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_START;
      pc_fetch_q         <= RESET_PC;
      hold_q             <= NOP;
      instr_id_q         <= NOP;
      pc_id_q            <= 32'h0;
      valid_id_q         <= 1'b0;
      redirect_pending_q <= 1'b0;
      redirect_pc_q      <= 32'h0;
    end else begin
      state_q            <= state_d;
      pc_fetch_q         <= pc_fetch_d;
      hold_q             <= hold_d;
      instr_id_q         <= instr_id_d;
      pc_id_q            <= pc_id_d;
      valid_id_q         <= valid_id_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_pc_q      <= redirect_pc_d;
    end
  end

  assign imem.imem_req  = issue & ~rst;
  assign imem.imem_addr = rst ? RESET_PC : (issue ? issue_addr : pc_fetch_q);
  assign instr_id       = instr_id_q;
  assign pc_id          = pc_id_q;
  assign valid_id       = valid_id_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed pipeline scenarios plus a
// randomized run checked against an instruction-stream reference model.
module tb_instr_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jumpBranch;
  logic        jumpTarget;
  logic        jumpReg;
  logic [31:0] jrPc;
  logic [31:0] instrId;
  logic [31:0] pcId;
  logic        validId;

  instr_fetch_if imemBus ();

  instr_fetch #(.RESET_PC(ResetPc)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump_branch (jumpBranch),
    .jump_target (jumpTarget),
    .jump_reg    (jumpReg),
    .jr_pc       (jrPc),
    .imem        (imemBus),
    .instr_id    (instrId),
    .pc_id       (pcId),
    .valid_id    (validId)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          latNext = 1;
  int          overlapCnt = 0;
  logic        memPend = 1'b0;
  logic [31:0] memAddr = 32'h0;
  int          memDue = 0;

  logic        obsReq;
  logic [31:0] obsAddr;
  logic        obsValid;
  logic [31:0] obsInstr;
  logic [31:0] obsPc;

  // Memory contents: a few fixed words for the directed scenarios, a hash elsewhere
  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2402_0005;
      32'h0000_0010: return 32'h1000_0003;
      32'hF000_0008: return 32'h0800_0040;
      default:       return a * 32'h9E37_79B1 + 32'h0135_7BDF;
    endcase
  endfunction

  // One clock cycle: observe outputs at negedge, then model the memory response
  task automatic step();
    @(negedge clk);
    obsReq   = imemBus.imem_req;
    obsAddr  = imemBus.imem_addr;
    obsValid = validId;
    obsInstr = instrId;
    obsPc    = pcId;
    if (rst) begin
      memPend = 1'b0;
    end else begin
      if (imemBus.imem_rvalid) memPend = 1'b0;
      if (obsReq) begin
        if (memPend) overlapCnt++;
        memPend = 1'b1;
        memAddr = obsAddr;
        memDue  = cyc + latNext;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    imemBus.imem_rvalid = memPend && (cyc == memDue);
    imemBus.imem_rdata  = (memPend && (cyc == memDue)) ? memword(memAddr) : $urandom;
  endtask

  task automatic applyReset();
    rst = 1'b1; stall = 1'b0; jumpBranch = 1'b0; jumpTarget = 1'b0; jumpReg = 1'b0;
    jrPc = 32'h0; latNext = 1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    rst = 1'b1;
    step();
    total++; if (obsReq !== 1'b0) begin bad++; $display("[TB] FAIL rst_req: got %b want 0", obsReq); end
    total++; if (obsAddr !== ResetPc) begin bad++; $display("[TB] FAIL rst_addr: got %h want %h", obsAddr, ResetPc); end
    total++; if (obsValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", obsValid); end
    total++; if (obsInstr !== 32'h0) begin bad++; $display("[TB] FAIL rst_instr: got %h want 0", obsInstr); end
    total++; if (obsPc !== 32'h0) begin bad++; $display("[TB] FAIL rst_pc: got %h want 0", obsPc); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (obsReq !== 1'b1 || obsAddr !== 32'(i * 4)) begin
        bad++; $display("[TB] FAIL seq_req%0d: got req=%b addr=%h want req=1 addr=%h", i, obsReq, obsAddr, 32'(i * 4));
      end
      if (i == 2) begin
        total++; if (obsValid !== 1'b1 || obsPc !== 32'h0 || obsInstr !== 32'h2402_0005) begin
          bad++; $display("[TB] FAIL first_id: got v=%b pc=%h ins=%h want v=1 pc=0 ins=24020005", obsValid, obsPc, obsInstr);
        end
      end
    end
  endtask

  task automatic test_stall();
    applyReset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (obsReq !== 1'b0) begin bad++; $display("[TB] FAIL stall_req%0d: got %b want 0", i, obsReq); end
      total++; if (obsInstr !== 32'h2402_0005 || obsPc !== 32'h0) begin
        bad++; $display("[TB] FAIL stall_id%0d: got pc=%h ins=%h want pc=0 ins=24020005", i, obsPc, obsInstr);
      end
    end
    stall = 1'b0;
    step();
    total++; if (obsReq !== 1'b1 || obsAddr !== 32'h8) begin
      bad++; $display("[TB] FAIL stall_release_req: got req=%b addr=%h want req=1 addr=8", obsReq, obsAddr);
    end
    step();
    total++; if (obsValid !== 1'b1 || obsPc !== 32'h4 || obsInstr !== memword(32'h4)) begin
      bad++; $display("[TB] FAIL stall_held_id: got v=%b pc=%h ins=%h want v=1 pc=4 ins=%h", obsValid, obsPc, obsInstr, memword(32'h4));
    end
  endtask

  task automatic test_branch();
    applyReset();
    for (int i = 0; i < 6; i++) step();
    jumpBranch = 1'b1;
    step();
    jumpBranch = 1'b0;
    total++; if (obsPc !== 32'h10) begin bad++; $display("[TB] FAIL beq_pc: got %h want 10", obsPc); end
    total++; if (obsReq !== 1'b1 || obsAddr !== 32'h20) begin
      bad++; $display("[TB] FAIL beq_target: got req=%b addr=%h want req=1 addr=20", obsReq, obsAddr);
    end
    step();
    total++; if (obsValid !== 1'b1 || obsPc !== 32'h14 || obsInstr !== memword(32'h14)) begin
      bad++; $display("[TB] FAIL beq_slot: got v=%b pc=%h ins=%h want v=1 pc=14", obsValid, obsPc, obsInstr);
    end
    step();
    total++; if (obsPc !== 32'h20) begin bad++; $display("[TB] FAIL beq_landing: got %h want 20", obsPc); end
  endtask

  task automatic test_jr_latency();
    applyReset();
    for (int i = 0; i < 5; i++) step();
    latNext = 3;
    step();
    latNext = 1;
    jumpReg = 1'b1;
    jrPc = 32'h100;
    step();
    jumpReg = 1'b0;
    total++; if (obsReq !== 1'b0) begin bad++; $display("[TB] FAIL jr_noissue: got %b want 0", obsReq); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (obsValid !== 1'b0 || obsInstr !== 32'h0 || obsPc !== 32'h10) begin
        bad++; $display("[TB] FAIL jr_bubble%0d: got v=%b ins=%h pc=%h want v=0 ins=0 pc=10", i, obsValid, obsInstr, obsPc);
      end
    end
    total++; if (obsReq !== 1'b1 || obsAddr !== 32'h100) begin
      bad++; $display("[TB] FAIL jr_target: got req=%b addr=%h want req=1 addr=100", obsReq, obsAddr);
    end
    step();
    total++; if (obsValid !== 1'b1 || obsPc !== 32'h14) begin
      bad++; $display("[TB] FAIL jr_slot: got v=%b pc=%h want v=1 pc=14", obsValid, obsPc);
    end
    total++; if (obsReq !== 1'b1 || obsAddr !== 32'h104) begin
      bad++; $display("[TB] FAIL jr_pending_clear: got req=%b addr=%h want req=1 addr=104", obsReq, obsAddr);
    end
    step();
    total++; if (obsPc !== 32'h100) begin bad++; $display("[TB] FAIL jr_landing: got %h want 100", obsPc); end
  endtask

  task automatic test_jump();
    applyReset();
    step();
    step();
    jumpReg = 1'b1;
    jrPc = 32'hF000_0000;
    step();
    jumpReg = 1'b0;
    total++; if (obsAddr !== 32'hF000_0000) begin bad++; $display("[TB] FAIL j_setup: got %h want f0000000", obsAddr); end
    for (int i = 0; i < 3; i++) step();
    jumpTarget = 1'b1;
    step();
    jumpTarget = 1'b0;
    total++; if (obsPc !== 32'hF000_0008) begin bad++; $display("[TB] FAIL j_pc: got %h want f0000008", obsPc); end
    total++; if (obsReq !== 1'b1 || obsAddr !== 32'hF000_0100) begin
      bad++; $display("[TB] FAIL j_target: got req=%b addr=%h want req=1 addr=f0000100", obsReq, obsAddr);
    end
    step();
    step();
    total++; if (obsPc !== 32'hF000_0100) begin bad++; $display("[TB] FAIL j_landing: got %h want f0000100", obsPc); end
  endtask

  task automatic test_reset_in_hold();
    applyReset();
    step();
    step();
    stall = 1'b1;
    step();
    total++; if (obsReq !== 1'b0) begin bad++; $display("[TB] FAIL hold_req: got %b want 0", obsReq); end
    step();
    rst = 1'b1;
    step();
    total++; if (obsReq !== 1'b0) begin bad++; $display("[TB] FAIL hold_rst_req: got %b want 0", obsReq); end
    step();
    total++; if (obsReq !== 1'b0 || obsAddr !== ResetPc) begin
      bad++; $display("[TB] FAIL hold_rst_bus: got req=%b addr=%h want req=0 addr=%h", obsReq, obsAddr, ResetPc);
    end
    total++; if (obsValid !== 1'b0 || obsInstr !== 32'h0 || obsPc !== 32'h0) begin
      bad++; $display("[TB] FAIL hold_rst_id: got v=%b ins=%h pc=%h want all 0", obsValid, obsInstr, obsPc);
    end
    rst = 1'b0;
    stall = 1'b0;
    step();
    total++; if (obsReq !== 1'b1 || obsAddr !== ResetPc) begin
      bad++; $display("[TB] FAIL hold_restart: got req=%b addr=%h want req=1 addr=%h", obsReq, obsAddr, ResetPc);
    end
    step();
    total++; if (obsValid !== 1'b0 || obsInstr !== 32'h0) begin
      bad++; $display("[TB] FAIL hold_stale: got v=%b ins=%h want v=0 ins=0", obsValid, obsInstr);
    end
    step();
    total++; if (obsValid !== 1'b1 || obsPc !== 32'h0 || obsInstr !== 32'h2402_0005) begin
      bad++; $display("[TB] FAIL hold_first: got v=%b pc=%h ins=%h want v=1 pc=0 ins=24020005", obsValid, obsPc, obsInstr);
    end
  endtask

  // Reference: the delivered stream is pc, pc+4, ... except that the word after a
  // redirecting instruction (its delay slot) is followed by the redirect target.
  task automatic test_random();
    logic [31:0] expPc;
    logic [31:0] expNext;
    logic [31:0] expInstr;
    logic [31:0] pc4;
    logic [31:0] tgt;
    int          off;
    int          consumed;
    int          idle;
    int          sel;
    applyReset();
    overlapCnt = 0;
    expPc = ResetPc;
    expNext = ResetPc + 32'd4;
    consumed = 0;
    idle = 0;
    for (int c = 0; c < 1500; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      sel = int'($urandom_range(0, 19));
      jumpReg = (sel == 0);
      jumpTarget = (sel == 1) || (sel == 3);
      jumpBranch = (sel == 2) || (sel == 3);
      jrPc = $urandom & 32'hFFFF_FFFC;
      latNext = int'($urandom_range(1, 3));
      step();
      if (obsValid && !stall) begin
        expInstr = memword(expPc);
        total++; if (obsPc !== expPc || obsInstr !== expInstr) begin
          bad++; $display("[TB] FAIL rnd_stream%0d: got pc=%h ins=%h want pc=%h ins=%h", consumed, obsPc, obsInstr, expPc, expInstr);
        end
        pc4 = expPc + 32'd4;
        off = $signed(expInstr[15:0]);
        if (jumpReg) tgt = jrPc;
        else if (jumpTarget) tgt = (pc4 & 32'hF000_0000) | (32'(expInstr[25:0]) << 2);
        else tgt = pc4 + 32'(off * 4);
        expPc = expNext;
        expNext = (jumpReg || jumpTarget || jumpBranch) ? tgt : expNext + 32'd4;
        consumed++;
        idle = 0;
      end else begin
        idle++;
        if (!obsValid) begin
          total++; if (obsInstr !== 32'h0) begin bad++; $display("[TB] FAIL rnd_bubble_nop: got %h want 0", obsInstr); end
        end
        if (idle > 60) begin
          total++; bad++;
          $display("[TB] FAIL rnd_progress: got %0d idle cycles want at most 60", idle);
          break;
        end
      end
    end
    stall = 1'b0; jumpReg = 1'b0; jumpTarget = 1'b0; jumpBranch = 1'b0;
    total++; if (consumed < 200) begin bad++; $display("[TB] FAIL rnd_throughput: got %0d want >= 200", consumed); end
    total++; if (overlapCnt !== 0) begin bad++; $display("[TB] FAIL rnd_one_outstanding: got %0d overlaps want 0", overlapCnt); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jumpBranch = 1'b0; jumpTarget = 1'b0; jumpReg = 1'b0; jrPc = 32'h0;
    imemBus.imem_rvalid = 1'b0;
    imemBus.imem_rdata = 32'h0;
    test_reset();
    test_stall();
    test_branch();
    test_jr_latency();
    test_jump();
    test_reset_in_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got no completion want finish before 1ms");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the pipelined MIPS core. It produces the instruction stream that the decode stage consumes. It keeps the fetch PC, issues one instruction-memory request at a time, and registers `instr_id`/`pc_id` for decode. It honours decode's `stall` and applies the branch/jump redirect that decode resolves, with MIPS single-delay-slot semantics.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  decode cannot accept a new instruction this cycle.
- `jump_branch`  in  1  the branch in ID is taken.
- `jump_target`  in  1  ID holds J/JAL.
- `jump_reg`  in  1  ID holds JR/JALR.
- `jr_pc`  in  32  register target (forwarded rs).
- `imem_req`  out  1  single-cycle request strobe.
- `imem_addr`  out  32  word address, bits [1:0]=0.
- `imem_rdata`  in  32  returned instruction.
- `imem_rvalid`  in  1  `imem_rdata` valid. Arrives at least 1 cycle after its request, exactly once per request.
- `instr_id`  out  32  instruction to decode.
- `pc_id`  out  32  its address.
- `valid_id`  out  1  0 means bubble.

## Operation
- State `pc_fetch` holds the address of the outstanding or next request. At most one request is outstanding.
- FSM states:
  - S_START: only entered from reset. Issues `RESET_PC` and goes to S_WAIT.
  - S_WAIT: a request is outstanding.
    - rvalid & ~stall: response loads into ID, the next request issues the same cycle, stay in S_WAIT.
    - rvalid & stall: response goes to the hold register, go to S_HOLD, no issue.
    - No rvalid & ~stall: ID becomes a bubble (`valid_id`=0, `instr_id`=32'h0 NOP, `pc_id` unchanged).
    - No rvalid & stall: ID is unchanged.
  - S_HOLD: while stall is high, ID and the hold register are unchanged. When ~stall, the hold register loads into ID, the next request issues, go to S_WAIT.
- Redirect is accepted only when `valid_id & ~stall`. While stall is high, the jump inputs are ignored.
- Redirect target priority: `jump_reg` → `jr_pc`; `jump_target` → {pc_id+4 [31:28], instr_id[25:0], 2'b00}; `jump_branch` → pc_id+4 + {sext(instr_id[15:0]), 2'b00}. Arithmetic is 32-bit and wraps modulo 2^32.
- Delay slot:
  - Fetch always runs exactly one instruction ahead of ID.
  - The in-flight or held instruction at redirect time is the delay slot. It is always delivered, never squashed.
  - The request after the delay slot uses the target.
  - If the redirect is accepted in the same cycle as the issue, the target drives `imem_addr` directly.
  - Otherwise the target is latched into `redirect_pc` and `redirect_pending` is set. The next issue uses it, then clears the pending bit.
- Next issue address: `redirect_pending ? redirect_pc : pc_fetch+4`, overridden by a same-cycle redirect.
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `instr_id`=0, `pc_id`=0, `valid_id`=0
  - hold register=0, `redirect_pending`=0, state=S_START
- Reset mid-operation: any outstanding request is abandoned. Instruction memory shares `rst` and must not return a response for a request issued before reset.

## Timing
- `imem_req`/`imem_addr` are combinational from state, `stall`, `imem_rvalid` and the redirect inputs. They are high for exactly one cycle per issue.
- First request is in the cycle after `rst` deasserts.
- With 1-cycle memory latency and no stall, throughput is one instruction per cycle. `instr_id` updates on the edge following `imem_rvalid`.
- Memory latency N adds N-1 bubble cycles per instruction when ID is not stalled.
- A redirect with no response in flight leaves ID as a bubble until the delay slot returns.

## Structure
- Add `` `NOP `` (32'h0000_0000) and `` `RESET_PC_DEFAULT `` to `mips_defines.v`.
- The FSM state encoding is local to this module.
- One natural sub-module: `branch_target`, purely combinational. Inputs: pc_id, instr_id, jr_pc, jump flags. Output: target address.

## Test plan
- Reset release with `RESET_PC`=0, latency 1, no stall: requests at 0x0, 0x4, 0x8, 0xC on consecutive cycles. The first fetched word 0x24020005 appears on `instr_id` with `pc_id`=0, `valid_id`=1 one cycle after its rvalid.
- Stall for 3 cycles arriving with rvalid:
  - `instr_id` is unchanged and no request issues.
  - On stall release, the held word enters ID and the request for pc+4 issues in that same cycle.
- Taken BEQ at `pc_id`=0x10 with imm 0x0003: the delay slot at 0x14 is delivered with `valid_id`=1, and the next `imem_addr` is 0x20.
- JR with `jr_pc`=0x100 while the delay slot has latency 3:
  - ID shows 2 bubbles (`instr_id`=0, `valid_id`=0), then instruction 0x14.
  - The next request is 0x100, and `redirect_pending` clears afterward.
- J at `pc_id`=0xF000_0008 with instr_index 0x40: the target is 0xF000_0100.
- `rst` asserted in S_HOLD: next cycle all outputs are at their reset values. The first request after release is `RESET_PC`, and no stale held instruction reaches ID.
